// File: rtl/ex_pipeline_regs.sv
// ex_pipeline_regs: ID/EX and EX/MEM pipeline registers for the 5-stage
// 64-bit ARM pipeline, plus the Z/N/C/V condition-flag register.
// Every output comes straight from a flop, so there is no combinational
// path from any input to any output.
module ex_pipeline_regs #(
   parameter int DATA_W = 64
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] id_da,
   input  logic [DATA_W-1:0] id_db,
   input  logic [DATA_W-1:0] id_daddr9,
   input  logic [DATA_W-1:0] id_imm12,
   input  logic [DATA_W-1:0] id_wd_pc,
   input  logic [DATA_W-1:0] id_pc,
   input  logic [DATA_W-1:0] id_stur_db,
   input  logic [31:0]       id_instr,
   input  logic [4:0]        id_rd,
   input  logic [4:0]        id_rn,
   input  logic [4:0]        id_rm,
   input  logic [2:0]        id_aluop,
   input  logic [3:0]        id_xfer_size,
   input  logic [10:0]       id_ctrl,
   output logic [DATA_W-1:0] ex_da,
   output logic [DATA_W-1:0] ex_db,
   output logic [DATA_W-1:0] ex_daddr9,
   output logic [DATA_W-1:0] ex_imm12,
   output logic [DATA_W-1:0] ex_wd_pc,
   output logic [DATA_W-1:0] ex_pc,
   output logic [DATA_W-1:0] ex_stur_db,
   output logic [31:0]       ex_instr,
   output logic [4:0]        ex_rd,
   output logic [4:0]        ex_rn,
   output logic [4:0]        ex_rm,
   output logic [2:0]        ex_aluop,
   output logic [3:0]        ex_xfer_size,
   output logic [10:0]       ex_ctrl,
   input  logic [DATA_W-1:0] alu_result,
   input  logic              is_neg,
   input  logic              is_zero,
   input  logic              is_overflow,
   input  logic              is_carry_out,
   output logic [DATA_W-1:0] mem_alu_result,
   output logic [DATA_W-1:0] mem_db,
   output logic [DATA_W-1:0] mem_da,
   output logic [DATA_W-1:0] mem_pc,
   output logic [DATA_W-1:0] mem_wd_pc,
   output logic [DATA_W-1:0] mem_daddr9,
   output logic [DATA_W-1:0] mem_stur_db,
   output logic [4:0]        mem_rd,
   output logic [3:0]        mem_xfer_size,
   output logic [7:0]        mem_ctrl,
   output logic              zero,
   output logic              negative,
   output logic              carry_out,
   output logic              overflow
);

   // ID/EX state
   logic [DATA_W-1:0] ex_da_d, ex_db_d, ex_daddr9_d, ex_imm12_d;
   logic [DATA_W-1:0] ex_wd_pc_d, ex_pc_d, ex_stur_db_d;
   logic [DATA_W-1:0] ex_da_q, ex_db_q, ex_daddr9_q, ex_imm12_q;
   logic [DATA_W-1:0] ex_wd_pc_q, ex_pc_q, ex_stur_db_q;
   logic [31:0]       ex_instr_d, ex_instr_q;
   logic [4:0]        ex_rd_d, ex_rn_d, ex_rm_d, ex_rd_q, ex_rn_q, ex_rm_q;
   logic [2:0]        ex_aluop_d, ex_aluop_q;
   logic [3:0]        ex_xfer_size_d, ex_xfer_size_q;
   logic [10:0]       ex_ctrl_d, ex_ctrl_q;

   // EX/MEM state
   logic [DATA_W-1:0] mem_alu_result_d, mem_db_d, mem_da_d, mem_pc_d;
   logic [DATA_W-1:0] mem_wd_pc_d, mem_daddr9_d, mem_stur_db_d;
   logic [DATA_W-1:0] mem_alu_result_q, mem_db_q, mem_da_q, mem_pc_q;
   logic [DATA_W-1:0] mem_wd_pc_q, mem_daddr9_q, mem_stur_db_q;
   logic [4:0]        mem_rd_d, mem_rd_q;
   logic [3:0]        mem_xfer_size_d, mem_xfer_size_q;
   logic [7:0]        mem_ctrl_d, mem_ctrl_q;

   // Flag register, packed as {zero, negative, carry_out, overflow}
   logic [3:0]        flags_d, flags_q;

   // Next-state for ID/EX: a straight copy of the Decode fields
   always_comb begin
      ex_da_d        = id_da;
      ex_db_d        = id_db;
      ex_daddr9_d    = id_daddr9;
      ex_imm12_d     = id_imm12;
      ex_wd_pc_d     = id_wd_pc;
      ex_pc_d        = id_pc;
      ex_stur_db_d   = id_stur_db;
      ex_instr_d     = id_instr;
      ex_rd_d        = id_rd;
      ex_rn_d        = id_rn;
      ex_rm_d        = id_rm;
      ex_aluop_d     = id_aluop;
      ex_xfer_size_d = id_xfer_size;
      ex_ctrl_d      = id_ctrl;
   end

   // Next-state for EX/MEM: fed from the ID/EX flops and the ALU, with the
   // Memory/Writeback control bits repacked into the narrower mem_ctrl map
   always_comb begin
      mem_alu_result_d = alu_result;
      mem_db_d         = ex_db_q;
      mem_da_d         = ex_da_q;
      mem_pc_d         = ex_pc_q;
      mem_wd_pc_d      = ex_wd_pc_q;
      mem_daddr9_d     = ex_daddr9_q;
      mem_stur_db_d    = ex_stur_db_q;
      mem_rd_d         = ex_rd_q;
      mem_xfer_size_d  = ex_xfer_size_q;
      mem_ctrl_d       = {is_overflow, is_neg, ex_ctrl_q[10], ex_ctrl_q[6],
                          ex_ctrl_q[5], ex_ctrl_q[2], ex_ctrl_q[4], ex_ctrl_q[3]};
   end

   // Flags load the current EX status only when the EX instruction sets flags
   always_comb begin
      flags_d = flags_q;
      if (ex_ctrl_q[7]) begin
         flags_d = {is_zero, is_neg, is_carry_out, is_overflow};
      end
   end

   // All pipeline and flag flops; the active-low reset clears them at once
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ex_da_q          <= '0;
         ex_db_q          <= '0;
         ex_daddr9_q      <= '0;
         ex_imm12_q       <= '0;
         ex_wd_pc_q       <= '0;
         ex_pc_q          <= '0;
         ex_stur_db_q     <= '0;
         ex_instr_q       <= '0;
         ex_rd_q          <= '0;
         ex_rn_q          <= '0;
         ex_rm_q          <= '0;
         ex_aluop_q       <= '0;
         ex_xfer_size_q   <= '0;
         ex_ctrl_q        <= '0;
         mem_alu_result_q <= '0;
         mem_db_q         <= '0;
         mem_da_q         <= '0;
         mem_pc_q         <= '0;
         mem_wd_pc_q      <= '0;
         mem_daddr9_q     <= '0;
         mem_stur_db_q    <= '0;
         mem_rd_q         <= '0;
         mem_xfer_size_q  <= '0;
         mem_ctrl_q       <= '0;
         flags_q          <= '0;
      end else begin
         ex_da_q          <= ex_da_d;
         ex_db_q          <= ex_db_d;
         ex_daddr9_q      <= ex_daddr9_d;
         ex_imm12_q       <= ex_imm12_d;
         ex_wd_pc_q       <= ex_wd_pc_d;
         ex_pc_q          <= ex_pc_d;
         ex_stur_db_q     <= ex_stur_db_d;
         ex_instr_q       <= ex_instr_d;
         ex_rd_q          <= ex_rd_d;
         ex_rn_q          <= ex_rn_d;
         ex_rm_q          <= ex_rm_d;
         ex_aluop_q       <= ex_aluop_d;
         ex_xfer_size_q   <= ex_xfer_size_d;
         ex_ctrl_q        <= ex_ctrl_d;
         mem_alu_result_q <= mem_alu_result_d;
         mem_db_q         <= mem_db_d;
         mem_da_q         <= mem_da_d;
         mem_pc_q         <= mem_pc_d;
         mem_wd_pc_q      <= mem_wd_pc_d;
         mem_daddr9_q     <= mem_daddr9_d;
         mem_stur_db_q    <= mem_stur_db_d;
         mem_rd_q         <= mem_rd_d;
         mem_xfer_size_q  <= mem_xfer_size_d;
         mem_ctrl_q       <= mem_ctrl_d;
         flags_q          <= flags_d;
      end
   end

   assign ex_da          = ex_da_q;
   assign ex_db          = ex_db_q;
   assign ex_daddr9      = ex_daddr9_q;
   assign ex_imm12       = ex_imm12_q;
   assign ex_wd_pc       = ex_wd_pc_q;
   assign ex_pc          = ex_pc_q;
   assign ex_stur_db     = ex_stur_db_q;
   assign ex_instr       = ex_instr_q;
   assign ex_rd          = ex_rd_q;
   assign ex_rn          = ex_rn_q;
   assign ex_rm          = ex_rm_q;
   assign ex_aluop       = ex_aluop_q;
   assign ex_xfer_size   = ex_xfer_size_q;
   assign ex_ctrl        = ex_ctrl_q;
   assign mem_alu_result = mem_alu_result_q;
   assign mem_db         = mem_db_q;
   assign mem_da         = mem_da_q;
   assign mem_pc         = mem_pc_q;
   assign mem_wd_pc      = mem_wd_pc_q;
   assign mem_daddr9     = mem_daddr9_q;
   assign mem_stur_db    = mem_stur_db_q;
   assign mem_rd         = mem_rd_q;
   assign mem_xfer_size  = mem_xfer_size_q;
   assign mem_ctrl       = mem_ctrl_q;
   assign zero           = flags_q[3];
   assign negative       = flags_q[2];
   assign carry_out      = flags_q[1];
   assign overflow       = flags_q[0];

endmodule

// File: tb/tb_ex_pipeline_regs.sv
// tb_ex_pipeline_regs: directed bench for the ID/EX + EX/MEM registers and
// the condition-flag register, with hand-computed expected values.
module tb_ex_pipeline_regs;

   localparam int DATA_W = 64;

   logic              clk;
   logic              reset;
   logic [DATA_W-1:0] id_da, id_db, id_daddr9, id_imm12, id_wd_pc, id_pc, id_stur_db;
   logic [31:0]       id_instr;
   logic [4:0]        id_rd, id_rn, id_rm;
   logic [2:0]        id_aluop;
   logic [3:0]        id_xfer_size;
   logic [10:0]       id_ctrl;
   logic [DATA_W-1:0] ex_da, ex_db, ex_daddr9, ex_imm12, ex_wd_pc, ex_pc, ex_stur_db;
   logic [31:0]       ex_instr;
   logic [4:0]        ex_rd, ex_rn, ex_rm;
   logic [2:0]        ex_aluop;
   logic [3:0]        ex_xfer_size;
   logic [10:0]       ex_ctrl;
   logic [DATA_W-1:0] alu_result;
   logic              is_neg, is_zero, is_overflow, is_carry_out;
   logic [DATA_W-1:0] mem_alu_result, mem_db, mem_da, mem_pc, mem_wd_pc, mem_daddr9, mem_stur_db;
   logic [4:0]        mem_rd;
   logic [3:0]        mem_xfer_size;
   logic [7:0]        mem_ctrl;
   logic              zero, negative, carry_out, overflow;

   int checks = 0;
   int errors = 0;

   ex_pipeline_regs #(.DATA_W(DATA_W)) dut (
      .clk(clk), .reset(reset),
      .id_da(id_da), .id_db(id_db), .id_daddr9(id_daddr9), .id_imm12(id_imm12),
      .id_wd_pc(id_wd_pc), .id_pc(id_pc), .id_stur_db(id_stur_db),
      .id_instr(id_instr), .id_rd(id_rd), .id_rn(id_rn), .id_rm(id_rm),
      .id_aluop(id_aluop), .id_xfer_size(id_xfer_size), .id_ctrl(id_ctrl),
      .ex_da(ex_da), .ex_db(ex_db), .ex_daddr9(ex_daddr9), .ex_imm12(ex_imm12),
      .ex_wd_pc(ex_wd_pc), .ex_pc(ex_pc), .ex_stur_db(ex_stur_db),
      .ex_instr(ex_instr), .ex_rd(ex_rd), .ex_rn(ex_rn), .ex_rm(ex_rm),
      .ex_aluop(ex_aluop), .ex_xfer_size(ex_xfer_size), .ex_ctrl(ex_ctrl),
      .alu_result(alu_result), .is_neg(is_neg), .is_zero(is_zero),
      .is_overflow(is_overflow), .is_carry_out(is_carry_out),
      .mem_alu_result(mem_alu_result), .mem_db(mem_db), .mem_da(mem_da),
      .mem_pc(mem_pc), .mem_wd_pc(mem_wd_pc), .mem_daddr9(mem_daddr9),
      .mem_stur_db(mem_stur_db), .mem_rd(mem_rd), .mem_xfer_size(mem_xfer_size),
      .mem_ctrl(mem_ctrl), .zero(zero), .negative(negative),
      .carry_out(carry_out), .overflow(overflow)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance past one rising edge; outputs are then sampled 1 time unit later
   task automatic applyStimulus();
      @(posedge clk);
      #1;
   endtask

   task automatic clearInputs();
      id_da = '0; id_db = '0; id_daddr9 = '0; id_imm12 = '0;
      id_wd_pc = '0; id_pc = '0; id_stur_db = '0; id_instr = '0;
      id_rd = '0; id_rn = '0; id_rm = '0; id_aluop = '0;
      id_xfer_size = '0; id_ctrl = '0; alu_result = '0;
      is_neg = 1'b0; is_zero = 1'b0; is_overflow = 1'b0; is_carry_out = 1'b0;
   endtask

   logic [10:0] mapIn  [6] = '{11'h008, 11'h010, 11'h004, 11'h020, 11'h040, 11'h400};
   logic [5:0]  mapOut [6] = '{6'h01,   6'h02,   6'h04,   6'h08,   6'h10,   6'h20};

   // Directed sequence
   initial begin
      reset = 1'b1;
      clearInputs();
      #2 reset = 1'b0;
      #1;
      $display("[TB] reset state");
      checkOutput("rst_ex_da", ex_da, 64'h0);
      checkOutput("rst_mem_ctrl", mem_ctrl, 64'h0);
      checkOutput("rst_flags", {zero, negative, carry_out, overflow}, 64'h0);
      applyStimulus();
      reset = 1'b1;

      // Reset mid-operation with flags already set
      $display("[TB] reset mid-operation");
      id_da = 64'hDEAD_BEEF_0123_4567;
      id_ctrl = 11'h080;
      is_zero = 1'b1;
      is_carry_out = 1'b1;
      applyStimulus();
      checkOutput("t1_ex_da", ex_da, 64'hDEAD_BEEF_0123_4567);
      applyStimulus();
      checkOutput("t1_mem_da", mem_da, 64'hDEAD_BEEF_0123_4567);
      checkOutput("t1_flags_set", {zero, negative, carry_out, overflow}, 64'hA);
      #2 reset = 1'b0;
      #1;
      checkOutput("t1_async_ex_da", ex_da, 64'h0);
      checkOutput("t1_async_mem_da", mem_da, 64'h0);
      checkOutput("t1_async_flags", {zero, negative, carry_out, overflow}, 64'h0);
      applyStimulus();
      checkOutput("t1_hold_ex_da", ex_da, 64'h0);
      checkOutput("t1_hold_flags", {zero, negative, carry_out, overflow}, 64'h0);
      reset = 1'b1;
      #2;
      checkOutput("t1_release_ex_da", ex_da, 64'h0);
      applyStimulus();
      checkOutput("t1_resume_ex_da", ex_da, 64'hDEAD_BEEF_0123_4567);
      checkOutput("t1_resume_mem_da", mem_da, 64'h0);
      clearInputs();
      applyStimulus();
      applyStimulus();

      // Latency of rd/ctrl
      $display("[TB] latency");
      id_rd = 5'd7;
      id_ctrl = 11'h040;
      applyStimulus();
      checkOutput("t2_ex_rd", ex_rd, 64'd7);
      checkOutput("t2_ex_ctrl", ex_ctrl, 64'h040);
      checkOutput("t2_mem_rd_early", mem_rd, 64'd0);
      clearInputs();
      applyStimulus();
      checkOutput("t2_mem_rd", mem_rd, 64'd7);
      checkOutput("t2_mem_regwrite", mem_ctrl[4], 64'd1);
      checkOutput("t2_ex_rd_next", ex_rd, 64'd0);

      // Flag enable and hold, plus ALU capture with Flag clear
      $display("[TB] flags and alu capture");
      id_ctrl = 11'h080;
      applyStimulus();
      id_ctrl = 11'h000;
      is_zero = 1'b1; is_neg = 1'b0; is_carry_out = 1'b1; is_overflow = 1'b0;
      applyStimulus();
      checkOutput("t3_flags_load", {zero, negative, carry_out, overflow}, 64'hA);
      is_zero = 1'b0; is_neg = 1'b1; is_carry_out = 1'b0; is_overflow = 1'b1;
      alu_result = 64'h0000_0000_0000_0014;
      applyStimulus();
      checkOutput("t3_flags_hold", {zero, negative, carry_out, overflow}, 64'hA);
      checkOutput("t4_mem_alu", mem_alu_result, 64'd20);
      checkOutput("t4_mem_status", mem_ctrl[7:6], 64'h3);
      id_ctrl = 11'h080;
      applyStimulus();
      id_ctrl = 11'h000;
      applyStimulus();
      checkOutput("t3_flags_load2", {zero, negative, carry_out, overflow}, 64'h5);
      clearInputs();
      applyStimulus();
      checkOutput("t4_mem_status_clr", mem_ctrl[7:6], 64'h0);

      // Back-to-back PC streaming
      $display("[TB] streaming");
      id_pc = 64'd4;
      applyStimulus();
      checkOutput("t5_ex_pc_4", ex_pc, 64'd4);
      id_pc = 64'd8;
      applyStimulus();
      checkOutput("t5_ex_pc_8", ex_pc, 64'd8);
      checkOutput("t5_mem_pc_4", mem_pc, 64'd4);
      id_pc = 64'd12;
      applyStimulus();
      checkOutput("t5_ex_pc_12", ex_pc, 64'd12);
      checkOutput("t5_mem_pc_8", mem_pc, 64'd8);
      id_pc = 64'd0;
      applyStimulus();
      checkOutput("t5_mem_pc_12", mem_pc, 64'd12);

      // Control mapping, all-ones then all-zeros, then one bit at a time
      $display("[TB] control mapping");
      id_ctrl = 11'h7FF;
      applyStimulus();
      checkOutput("t6_ex_ctrl_ff", ex_ctrl, 64'h7FF);
      id_ctrl = 11'h000;
      applyStimulus();
      checkOutput("t6_mem_ctrl_3f", mem_ctrl[5:0], 64'h3F);
      applyStimulus();
      checkOutput("t6_mem_ctrl_00", mem_ctrl[5:0], 64'h00);
      for (int i = 0; i < 6; i++) begin
         id_ctrl = mapIn[i];
         applyStimulus();
         id_ctrl = 11'h000;
         applyStimulus();
         checkOutput($sformatf("t6_map_%0d", i), mem_ctrl[5:0], 64'(mapOut[i]));
      end

      // Every datapath field at once with distinct values
      $display("[TB] all fields");
      id_da = 64'h1111_2222_3333_4444;
      id_db = 64'h5555_6666_7777_8888;
      id_daddr9 = 64'hFFFF_FFFF_FFFF_FF00;
      id_imm12 = 64'h0000_0000_0000_0ABC;
      id_wd_pc = 64'h0000_0000_0000_1234;
      id_stur_db = 64'h9999_AAAA_BBBB_CCCC;
      id_pc = 64'h8000_0000_0000_0040;
      id_instr = 32'hF840_03E1;
      id_rd = 5'd30; id_rn = 5'd17; id_rm = 5'd9;
      id_aluop = 3'd5; id_xfer_size = 4'b1010;
      applyStimulus();
      checkOutput("f_ex_db", ex_db, 64'h5555_6666_7777_8888);
      checkOutput("f_ex_daddr9", ex_daddr9, 64'hFFFF_FFFF_FFFF_FF00);
      checkOutput("f_ex_imm12", ex_imm12, 64'h0000_0000_0000_0ABC);
      checkOutput("f_ex_instr", ex_instr, 64'hF840_03E1);
      checkOutput("f_ex_rn", ex_rn, 64'd17);
      checkOutput("f_ex_rm", ex_rm, 64'd9);
      checkOutput("f_ex_aluop", ex_aluop, 64'd5);
      checkOutput("f_ex_stur", ex_stur_db, 64'h9999_AAAA_BBBB_CCCC);
      clearInputs();
      applyStimulus();
      checkOutput("f_mem_da", mem_da, 64'h1111_2222_3333_4444);
      checkOutput("f_mem_db", mem_db, 64'h5555_6666_7777_8888);
      checkOutput("f_mem_daddr9", mem_daddr9, 64'hFFFF_FFFF_FFFF_FF00);
      checkOutput("f_mem_wd_pc", mem_wd_pc, 64'h0000_0000_0000_1234);
      checkOutput("f_mem_stur", mem_stur_db, 64'h9999_AAAA_BBBB_CCCC);
      checkOutput("f_mem_pc", mem_pc, 64'h8000_0000_0000_0040);
      checkOutput("f_mem_rd", mem_rd, 64'd30);
      checkOutput("f_mem_xfer", mem_xfer_size, 64'hA);
      checkOutput("f_ex_clear", ex_da, 64'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ex_pipeline_regs.md
Name: ex_pipeline_regs

Overview:
- Combined ID/EX and EX/MEM pipeline register block for the 5-stage 64-bit ARM pipeline, plus the enabled condition-flag register (Z/N/C/V).
- Captures decoded operands and control from Decode, presents them to Execute, then forwards them with the ALU result to Memory.
- Purely registered: no combinational input-to-output path.

Parameters:
- DATA_W, 64, width of all datapath fields.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- id_da, id_db, id_daddr9, id_imm12, id_wd_pc, id_pc, id_stur_db  input  DATA_W each  Decode fields:
  - Rn data.
  - Operand B after the ALUSrc mux.
  - Sign-extended DAddr9.
  - Zero-extended Imm12.
  - Write-data/return-PC value.
  - noBr PC.
  - Raw store data.
- id_instr  input  32  decoded instruction word.
- id_rd, id_rn, id_rm  input  5 each  destination (Rd or X30), source register numbers.
- id_aluop  input  3  ALU operation.
- id_xfer_size  input  4  memory transfer size.
- id_ctrl  input  11  control bits:
  - [0] ALUSrc, [1] immediate, [2] BL_op, [3] MemWrite.
  - [4] MemRead, [5] MemtoReg, [6] RegWrite, [7] Flag.
  - [8] UncondBr, [9] BrTaken, [10] loadop.
- ex_da, ex_db, ex_daddr9, ex_imm12, ex_wd_pc, ex_pc, ex_stur_db  output  DATA_W each  ID/EX registered copies.
- ex_instr  output  32;  ex_rd, ex_rn, ex_rm  output  5 each;  ex_aluop  output  3;  ex_xfer_size  output  4;  ex_ctrl  output  11  ID/EX registered copies, same bit map.
- alu_result  input  DATA_W  Execute-stage ALU result.
- is_neg, is_zero, is_overflow, is_carry_out  input  1 each  ALU status for the current EX instruction.
- mem_alu_result, mem_db, mem_da, mem_pc, mem_wd_pc, mem_daddr9, mem_stur_db  output  DATA_W each  EX/MEM registered fields.
- mem_rd  output  5;  mem_xfer_size  output  4.
- mem_ctrl  output  8  EX/MEM control bits:
  - [0] MemWrite, [1] MemRead, [2] BL_op, [3] MemtoReg.
  - [4] RegWrite, [5] loadop, [6] is_neg, [7] is_overflow.
- zero, negative, carry_out, overflow  output  1 each  architectural flag register.

Behaviour:
- Clocking and reset:
  - All state updates on the rising edge of clk.
  - No stall, enable or flush inputs; every register loads every cycle.
  - reset low: immediately and asynchronously clears every output (ex_*, mem_*, flags) to 0.
  - Registers hold 0 while reset is low. Normal capture resumes on the first rising edge after reset goes high.
  - Reset dominates any simultaneous clock edge or flag enable.
- ID/EX stage: each ex_* output equals its id_* input sampled at the previous rising edge (latency 1).
- EX/MEM stage: loads from the ID/EX outputs, not the id_* inputs (id -> mem latency 2).
  - mem_db <- ex_db, mem_da <- ex_da, mem_pc <- ex_pc, mem_wd_pc <- ex_wd_pc, mem_daddr9 <- ex_daddr9, mem_stur_db <- ex_stur_db.
  - mem_rd <- ex_rd, mem_xfer_size <- ex_xfer_size.
  - mem_ctrl[5:0] <- {ex_ctrl[10], ex_ctrl[6], ex_ctrl[5], ex_ctrl[2], ex_ctrl[4], ex_ctrl[3]}.
  - mem_alu_result <- alu_result; mem_ctrl[6] <- is_neg; mem_ctrl[7] <- is_overflow. These load unconditionally.
- Flag register:
  - At a rising edge with ex_ctrl[7] (registered Flag) = 1: zero, negative, carry_out, overflow <- is_zero, is_neg, is_carry_out, is_overflow.
  - With ex_ctrl[7] = 0: all four hold their value.
  - Enable is the ID/EX copy, so flags update one cycle after the flag-setting instruction leaves Decode, with that instruction's ALU status.
- Width rules: pure storage, no arithmetic, no truncation; all fields pass bit-exact.

Test Plan:
1. Reset mid-operation:
   - Stimulus: load id_da=64'hDEAD_BEEF_0123_4567 for two cycles, then drive reset low between clock edges.
   - Response: ex_da, mem_da and all flags go to 0 before the next edge and stay 0 until reset high plus one edge.
2. Latency:
   - Stimulus: id_rd=5'd7, id_ctrl=11'h040 (RegWrite) at edge N.
   - Response: ex_rd=7 and ex_ctrl=11'h040 after edge N; mem_rd=7 and mem_ctrl[4]=1 after edge N+1.
3. Flag enable:
   - Stimulus: ex_ctrl[7]=1 with is_zero=1, is_neg=0, is_carry_out=1, is_overflow=0.
   - Response: zero=1, negative=0, carry_out=1, overflow=0.
   - Follow-up: next cycle, ex_ctrl[7]=0 with is_zero=0 -> all flags unchanged.
4. ALU capture:
   - Stimulus: alu_result=64'h0000_0000_0000_0014, is_neg=1, is_overflow=1.
   - Response: next edge gives mem_alu_result=20 and mem_ctrl[7:6]=2'b11, regardless of ex_ctrl[7].
5. Back-to-back streaming:
   - Stimulus: id_pc=4, 8, 12 on consecutive edges.
   - Response: ex_pc follows one cycle later and mem_pc two cycles later, with no bubbles or duplicates.
6. Control mapping:
   - Stimulus: id_ctrl=11'h7FF, then 11'h000.
   - Response: mem_ctrl[5:0]=6'h3F, then 6'h00, two edges later each.
